sync_split_fifo_param: RTL

- Parametrised two-channel synchronous split FIFO. Two fully independent FIFOs share one clock and one global reset; each channel has its own width, depth, thresholds and pointer flush.
- It is the generalised successor to the fixed R18W18/R9W9 split FIFO primitive mapping. It adds a selectable first-word-fall-through (FWFT) or standard read mode, programmable watermarks, and occupancy count outputs.
- It sits between user logic and the BRAM FIFO primitive models.

---
 rtl/sync_split_fifo_param.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sync_split_fifo_param.sv
// sync_split_fifo_param
//   Two independent synchronous FIFOs sharing one clock and one global reset.
//   Each channel has its own width, depth, watermarks and pointer flush, and
//   the read port is either first-word-fall-through (FWFT=1) or standard with
//   one cycle of read latency (FWFT=0).
//
// Ports (n = 1, 2):
//   clock0            rising-edge clock for both channels
//   rst_n             asynchronous active-low global reset
//   rst_ptrn          synchronous flush of channel n (other channel untouched)
//   wen / dinn        write enable / write data
//   ren / doutn       read enable / read data
//   countn            occupancy, 0..DEPTHn
//   EMPTYn EPOn EWMn  empty, one-left, at-or-below PROG_EMPTYn
//   UNDERRUNn         one-cycle pulse after a read attempted while empty
//   FULLn FMOn FWMn   full, one-slot-left, at-or-above PROG_FULLn
//   OVERRUNn          one-cycle pulse after a write attempted while full

// Single FIFO channel. All flags are registered from the next-state count so
// they change on the same edge as count.
module sync_split_fifo_chan #(
  parameter int WIDTH      = 18,
  parameter int DEPTH      = 1024,
  parameter int PROG_EMPTY = 4,
  parameter int PROG_FULL  = DEPTH - 4,
  parameter int FWFT       = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rst_ptr,
  input  logic                     we,
  input  logic [WIDTH-1:0]         din,
  input  logic                     re,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     epo,
  output logic                     ewm,
  output logic                     underrun,
  output logic                     full,
  output logic                     fmo,
  output logic                     fwm,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_FMO  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] C_PE   = CW'(PROG_EMPTY);
  localparam logic [CW-1:0] C_PF   = CW'(PROG_FULL);
  localparam logic [AW-1:0] P_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic          wr_acc, rd_acc;
  logic          dout_load;
  logic [WIDTH-1:0] dout_nxt;

  // Acceptance uses the registered flags; a flush overrides any request.
  always_comb begin
    wr_acc     = we & ~full  & ~rst_ptr;
    rd_acc     = re & ~empty & ~rst_ptr;
    wr_ptr_nxt = wr_acc ? wr_ptr + P_ONE : wr_ptr;
    rd_ptr_nxt = rd_acc ? rd_ptr + P_ONE : rd_ptr;
    count_nxt  = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + C_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - C_ONE;
    end
  end

  // Output data selection.
  // FWFT: dout tracks the head word after every edge that leaves the FIFO
  // non-empty. The head can be the word being written on this same edge (only
  // when the FIFO is otherwise empty), so that case bypasses din.
  // Standard: dout loads the head only on an accepted read.
  always_comb begin
    dout_load = 1'b0;
    dout_nxt  = dout;
    if (FWFT != 0) begin
      if (count_nxt != '0) begin
        dout_load = 1'b1;
        if (wr_acc && (wr_ptr == rd_ptr_nxt)) begin
          dout_nxt = din;
        end else begin
          dout_nxt = mem[rd_ptr_nxt];
        end
      end
    end else if (rd_acc) begin
      dout_load = 1'b1;
      dout_nxt  = mem[rd_ptr];
    end
  end

  // Storage array: no reset, written only on accepted writes.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, count and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      epo      <= 1'b0;
      ewm      <= 1'b1;
      full     <= 1'b0;
      fmo      <= 1'b0;
      fwm      <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else if (rst_ptr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      epo      <= 1'b0;
      ewm      <= 1'b1;
      full     <= 1'b0;
      fmo      <= 1'b0;
      fwm      <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      empty    <= (count_nxt == '0);
      epo      <= (count_nxt == C_ONE);
      ewm      <= (count_nxt <= C_PE);
      full     <= (count_nxt == C_FULL);
      fmo      <= (count_nxt == C_FMO);
      fwm      <= (count_nxt >= C_PF);
      underrun <= re & empty;
      overrun  <= we & full;
    end
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (rst_ptr) begin
      dout <= '0;
    end else if (dout_load) begin
      dout <= dout_nxt;
    end
  end

endmodule

module sync_split_fifo_param #(
  parameter int DATA_WIDTH1 = 18,
  parameter int DEPTH1      = 1024,
  parameter int DATA_WIDTH2 = 9,
  parameter int DEPTH2      = 2048,
  parameter int PROG_EMPTY1 = 4,
  parameter int PROG_EMPTY2 = 4,
  parameter int PROG_FULL1  = DEPTH1 - 4,
  parameter int PROG_FULL2  = DEPTH2 - 4,
  parameter int FWFT        = 1
) (
  input  logic                      clock0,
  input  logic                      rst_n,
  input  logic                      rst_ptr1,
  input  logic                      rst_ptr2,
  input  logic                      we1,
  input  logic                      we2,
  input  logic [DATA_WIDTH1-1:0]    din1,
  input  logic [DATA_WIDTH2-1:0]    din2,
  input  logic                      re1,
  input  logic                      re2,
  output logic [DATA_WIDTH1-1:0]    dout1,
  output logic [DATA_WIDTH2-1:0]    dout2,
  output logic [$clog2(DEPTH1):0]   count1,
  output logic [$clog2(DEPTH2):0]   count2,
  output logic                      EMPTY1,
  output logic                      EMPTY2,
  output logic                      EPO1,
  output logic                      EPO2,
  output logic                      EWM1,
  output logic                      EWM2,
  output logic                      UNDERRUN1,
  output logic                      UNDERRUN2,
  output logic                      FULL1,
  output logic                      FULL2,
  output logic                      FMO1,
  output logic                      FMO2,
  output logic                      FWM1,
  output logic                      FWM2,
  output logic                      OVERRUN1,
  output logic                      OVERRUN2
);

  sync_split_fifo_chan #(
    .WIDTH      (DATA_WIDTH1),
    .DEPTH      (DEPTH1),
    .PROG_EMPTY (PROG_EMPTY1),
    .PROG_FULL  (PROG_FULL1),
    .FWFT       (FWFT)
  ) u_ch1 (
    .clk      (clock0),
    .rst_n    (rst_n),
    .rst_ptr  (rst_ptr1),
    .we       (we1),
    .din      (din1),
    .re       (re1),
    .dout     (dout1),
    .count    (count1),
    .empty    (EMPTY1),
    .epo      (EPO1),
    .ewm      (EWM1),
    .underrun (UNDERRUN1),
    .full     (FULL1),
    .fmo      (FMO1),
    .fwm      (FWM1),
    .overrun  (OVERRUN1)
  );

  sync_split_fifo_chan #(
    .WIDTH      (DATA_WIDTH2),
    .DEPTH      (DEPTH2),
    .PROG_EMPTY (PROG_EMPTY2),
    .PROG_FULL  (PROG_FULL2),
    .FWFT       (FWFT)
  ) u_ch2 (
    .clk      (clock0),
    .rst_n    (rst_n),
    .rst_ptr  (rst_ptr2),
    .we       (we2),
    .din      (din2),
    .re       (re2),
    .dout     (dout2),
    .count    (count2),
    .empty    (EMPTY2),
    .epo      (EPO2),
    .ewm      (EWM2),
    .underrun (UNDERRUN2),
    .full     (FULL2),
    .fmo      (FMO2),
    .fwm      (FWM2),
    .overrun  (OVERRUN2)
  );

endmodule
